phase_sweep_ctrl: RTL
=====================

Name: phase_sweep_ctrl

Overview:
- Avalon-MM slave sequencer that steps a 12-bit phase word through a programmed range.
- Holds each phase value for a programmable dwell time, then captures the returned sensor word.
- Sits between the HPS lightweight bridge and the phase-shift datapath, replacing manual per-step CPU writes to the phase PIO.
- Raises an interrupt when a sweep completes.

Parameters:
- PHASE_W, 12, width of phase word and sample word
- DWELL_W, 16, width of dwell counter and DWELL register

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  3  word register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- phase_out  out  PHASE_W  phase word to datapath
- phase_valid  out  1  one-cycle pulse each time phase_out takes a new value
- sample_in  in  PHASE_W  sensor/phase feedback word
- irq  out  1  level interrupt, equals done & irq_en

Behaviour:
- Register map (word address):
  - 0 CTRL: bit0 GO (write-1 pulse), bit1 ABORT (write-1 pulse), bit2 CONTINUOUS, bit3 IRQ_EN.
  - 1 START, 2 STOP, 3 STEP (all PHASE_W).
  - 4 DWELL (DWELL_W).
  - 5 STATUS: bit0 BUSY (read-only), bit1 DONE (sticky, write 1 clears).
  - 6 LAST_SAMPLE (read-only).
  - 7 CUR_PHASE (read-only).
- Reads:
  - readdata is registered every cycle from the address mux, 1-cycle latency; chipselect is not required for reads.
  - Unused bits read 0.
- Writes: occur when chipselect & ~write_n.
- Reset values: all registers, readdata, phase_out, LAST_SAMPLE, DONE, phase_valid and irq are 0; FSM in IDLE.
- FSM states: IDLE, LOAD, DWELL, CAPTURE, ADVANCE.
  - IDLE: on GO go to LOAD. GO while not IDLE is ignored.
  - LOAD (1 cycle): phase_out <= START; phase_valid=1; cnt <= max(DWELL,1); go to DWELL.
  - DWELL: decrement cnt each cycle; at cnt==1 go to CAPTURE. Dwell therefore lasts max(DWELL,1) cycles.
  - CAPTURE (1 cycle): LAST_SAMPLE <= sample_in.
    - If phase_out == STOP: with CONTINUOUS set, go to LOAD; otherwise set DONE and go to IDLE.
    - Otherwise go to ADVANCE.
  - ADVANCE (1 cycle): nxt = phase_out + max(STEP,1), computed PHASE_W+1 wide. phase_out <= (nxt > STOP) ? STOP : nxt; phase_valid=1; reload cnt; go to DWELL.
- Range rules:
  - Sweep is upward only; there is no wrap-around.
  - If START > STOP, exactly one point (START) is produced, then the sweep terminates (treated as phase_out==STOP after clamp check fails; compare START>=STOP in CAPTURE).
  - Termination condition is phase_out >= STOP.
- BUSY = (state != IDLE).
- ABORT: in any state, next state is IDLE. phase_out holds, DONE is not set, no capture occurs. ABORT wins over GO in the same write.
- Config writes while BUSY:
  - STOP, STEP and DWELL take effect at the next CAPTURE/ADVANCE/reload.
  - START takes effect at the next LOAD.
- Simultaneous DONE set (CAPTURE) and software DONE clear in the same cycle: set wins.
- A reset mid-sweep forces all reset values immediately.

Optional Feature:
- Macro PHASE_SWEEP_DOWN_EN.
- Defined:
  - CTRL bit4 DIR_DOWN is implemented.
  - When set, ADVANCE computes nxt = phase_out − max(STEP,1) and clamps to STOP if nxt < STOP or on underflow.
  - Termination condition becomes phase_out <= STOP.
- Undefined: CTRL bit4 reads 0, writes are ignored, and the block is upward-only.

Decomposition:
- Shared package phase_sweep_pkg holds:
  - register address constants (ADDR_CTRL … ADDR_CUR_PHASE)
  - CTRL/STATUS bit index constants
  - FSM state enum typedef
- One sub-module, phase_sweep_regs: the Avalon register file, readdata mux and GO/ABORT pulse generation.
- The FSM and datapath stay in the top module.

Test Plan:
- Basic sweep: START=0x100, STOP=0x130, STEP=0x10, DWELL=3, GO.
  - phase_valid pulses with phase_out 0x100, 0x110, 0x120, 0x130, each held 3 cycles in DWELL.
  - Four captures occur; DONE=1; irq=1 with IRQ_EN set.
- Clamp: START=0xFF0, STOP=0xFFF, STEP=0x20.
  - Produces 0xFF0 then 0xFFF, with no wrap to 0x010; DONE set.
- Zero values: STEP=0, DWELL=0, START=5, STOP=7.
  - Produces 5, 6, 7 with 1-cycle dwell each.
  - LAST_SAMPLE equals the sample_in value at the third CAPTURE.
- Abort: abort mid-DWELL at phase 0x110.
  - BUSY clears next cycle, phase_out stays 0x110, DONE=0.
  - A subsequent GO restarts at START.
- Continuous mode: CONTINUOUS=1 with START=0, STOP=2, STEP=1.
  - Sequence 0, 1, 2, 0, 1 … until ABORT; DONE never sets.
- Reset and readback:
  - Assert reset mid-sweep: all outputs return to 0 asynchronously.
  - Read STATUS after reset: 0; read latency is exactly 1 cycle.

Source files
------------

// File: rtl/phase_sweep_pkg.sv
// Shared constants and state encoding for the phase sweep sequencer.
// Register map word addresses, CTRL/STATUS bit positions, FSM states.
package phase_sweep_pkg;
  localparam logic [2:0] ADDR_CTRL        = 3'd0;
  localparam logic [2:0] ADDR_START       = 3'd1;
  localparam logic [2:0] ADDR_STOP        = 3'd2;
  localparam logic [2:0] ADDR_STEP        = 3'd3;
  localparam logic [2:0] ADDR_DWELL       = 3'd4;
  localparam logic [2:0] ADDR_STATUS      = 3'd5;
  localparam logic [2:0] ADDR_LAST_SAMPLE = 3'd6;
  localparam logic [2:0] ADDR_CUR_PHASE   = 3'd7;

  localparam int CTRL_GO       = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_CONT     = 2;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int CTRL_DIR_DOWN = 4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DWELL   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_ADVANCE = 3'd4
  } state_t;
endpackage

// File: rtl/phase_sweep_ctrl_if.sv
// Avalon-MM slave bus bundle for the phase sweep sequencer.
interface phase_sweep_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/phase_sweep_regs.sv
// Register file, registered read mux and GO/ABORT pulse generation.
// PHASE_SWEEP_DOWN_EN adds the CTRL DIR_DOWN bit.
module phase_sweep_regs
  import phase_sweep_pkg::*;
#(
  parameter int PHASE_W = 12,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  phase_sweep_ctrl_if.slave  bus,
  input  logic               busy,
  input  logic               done_set,
  input  logic [PHASE_W-1:0] cur_phase,
  input  logic [PHASE_W-1:0] last_sample,
  output logic [PHASE_W-1:0] start,
  output logic [PHASE_W-1:0] stop,
  output logic [PHASE_W-1:0] step,
  output logic [DWELL_W-1:0] dwell,
  output logic               continuous,
  output logic               irq_en,
  output logic               dir_down,
  output logic               go,
  output logic               abort,
  output logic               done
);
  logic        wr, wr_ctrl;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign wr_ctrl      = wr && (bus.address == ADDR_CTRL);
  assign unused_wdata = ^bus.writedata[31:DWELL_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start        <= '0;
      stop         <= '0;
      step         <= '0;
      dwell        <= '0;
      continuous   <= 1'b0;
      irq_en       <= 1'b0;
      go           <= 1'b0;
      abort        <= 1'b0;
      done         <= 1'b0;
      bus.readdata <= '0;
    end else begin
      // ABORT in the same write suppresses GO
      go    <= wr_ctrl && bus.writedata[CTRL_GO] && !bus.writedata[CTRL_ABORT];
      abort <= wr_ctrl && bus.writedata[CTRL_ABORT];
      if (wr) begin
        case (bus.address)
          ADDR_CTRL: begin
            continuous <= bus.writedata[CTRL_CONT];
            irq_en     <= bus.writedata[CTRL_IRQ_EN];
          end
          ADDR_START: start <= bus.writedata[PHASE_W-1:0];
          ADDR_STOP:  stop  <= bus.writedata[PHASE_W-1:0];
          ADDR_STEP:  step  <= bus.writedata[PHASE_W-1:0];
          ADDR_DWELL: dwell <= bus.writedata[DWELL_W-1:0];
          default: ;
        endcase
      end
      // hardware set beats a software clear landing in the same cycle
      if (done_set)
        done <= 1'b1;
      else if (wr && bus.address == ADDR_STATUS && bus.writedata[STAT_DONE])
        done <= 1'b0;
      bus.readdata <= rd_mux;
    end
  end

`ifdef PHASE_SWEEP_DOWN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        dir_down <= 1'b0;
    else if (wr_ctrl) dir_down <= bus.writedata[CTRL_DIR_DOWN];
  end
`else
  assign dir_down = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_CTRL: begin
        rd_mux[CTRL_CONT]     = continuous;
        rd_mux[CTRL_IRQ_EN]   = irq_en;
        rd_mux[CTRL_DIR_DOWN] = dir_down;
      end
      ADDR_START:       rd_mux[PHASE_W-1:0] = start;
      ADDR_STOP:        rd_mux[PHASE_W-1:0] = stop;
      ADDR_STEP:        rd_mux[PHASE_W-1:0] = step;
      ADDR_DWELL:       rd_mux[DWELL_W-1:0] = dwell;
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_DONE] = done;
      end
      ADDR_LAST_SAMPLE: rd_mux[PHASE_W-1:0] = last_sample;
      ADDR_CUR_PHASE:   rd_mux[PHASE_W-1:0] = cur_phase;
      default: ;
    endcase
  end
endmodule

// File: rtl/phase_sweep_ctrl.sv
// Phase sweep sequencer: steps phase_out START..STOP, dwells, captures sample_in.
// Define PHASE_SWEEP_DOWN_EN to enable downward sweeps via CTRL DIR_DOWN.
module phase_sweep_ctrl
  import phase_sweep_pkg::*;
#(
  parameter int PHASE_W = 12,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  phase_sweep_ctrl_if.slave  bus,
  output logic [PHASE_W-1:0] phase_out,
  output logic               phase_valid,
  input  logic [PHASE_W-1:0] sample_in,
  output logic               irq
);
  state_t             state;
  logic [DWELL_W-1:0] cnt, dwell_eff, dwell;
  logic [PHASE_W-1:0] start, stop, step, step_eff, last_sample, nxt_phase;
  logic [PHASE_W:0]   nxt;
  logic               continuous, irq_en, dir_down, go, abort, done, done_set, term;

  phase_sweep_regs #(.PHASE_W(PHASE_W), .DWELL_W(DWELL_W)) u_regs (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (state != ST_IDLE),
    .done_set    (done_set),
    .cur_phase   (phase_out),
    .last_sample (last_sample),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .dwell       (dwell),
    .continuous  (continuous),
    .irq_en      (irq_en),
    .dir_down    (dir_down),
    .go          (go),
    .abort       (abort),
    .done        (done)
  );

  assign step_eff  = (step == '0)  ? PHASE_W'(1) : step;
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign done_set  = (state == ST_CAPTURE) && term && !continuous && !abort;
  assign irq       = done & irq_en;

  // one extra bit so the clamp sees overflow past the top of the phase range
  always_comb begin
    nxt       = {1'b0, phase_out} + {1'b0, step_eff};
    nxt_phase = (nxt > {1'b0, stop}) ? stop : nxt[PHASE_W-1:0];
    term      = (phase_out >= stop);
`ifdef PHASE_SWEEP_DOWN_EN
    if (dir_down) begin
      nxt       = {1'b0, phase_out} - {1'b0, step_eff};
      nxt_phase = (nxt[PHASE_W] || nxt[PHASE_W-1:0] < stop) ? stop : nxt[PHASE_W-1:0];
      term      = (phase_out <= stop);
    end
`endif
  end

`ifndef PHASE_SWEEP_DOWN_EN
  logic unused_dir;
  assign unused_dir = dir_down;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      phase_out   <= '0;
      phase_valid <= 1'b0;
      last_sample <= '0;
    end else begin
      phase_valid <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (go) state <= ST_LOAD;
          ST_LOAD: begin
            phase_out   <= start;
            phase_valid <= 1'b1;
            cnt         <= dwell_eff;
            state       <= ST_DWELL;
          end
          ST_DWELL: begin
            if (cnt == DWELL_W'(1)) state <= ST_CAPTURE;
            else                    cnt   <= cnt - 1'b1;
          end
          ST_CAPTURE: begin
            last_sample <= sample_in;
            if (term) state <= continuous ? ST_LOAD : ST_IDLE;
            else      state <= ST_ADVANCE;
          end
          ST_ADVANCE: begin
            phase_out   <= nxt_phase;
            phase_valid <= 1'b1;
            cnt         <= dwell_eff;
            state       <= ST_DWELL;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
